// File: rtl/datamem_pkg.sv
// Shared constants and transfer-legality helpers for the MEM-stage data memory.
package datamem_pkg;

  localparam int unsigned DATA_MEM_SIZE_DEFAULT = 1024;
  localparam int unsigned LANES                 = 8;
  localparam int unsigned ADDR_W                = 64;
  localparam int unsigned DATA_W                = 64;
  localparam int unsigned SIZE_W                = 4;

  function automatic logic is_valid_xfer(input logic [SIZE_W-1:0] xfer_size);
    return (xfer_size == 4'd1) || (xfer_size == 4'd2) ||
           (xfer_size == 4'd4) || (xfer_size == 4'd8);
  endfunction

  // 65-bit end address so a transfer near 2^64 cannot wrap back into range
  function automatic logic access_ok(input logic [ADDR_W-1:0] address,
                                     input logic [SIZE_W-1:0] xfer_size,
                                     input logic [ADDR_W-1:0] size);
    logic          aligned;
    logic [ADDR_W:0] end_addr;
    aligned  = (address & (ADDR_W'(xfer_size) - ADDR_W'(1))) == '0;
    end_addr = (ADDR_W+1)'(address) + (ADDR_W+1)'(xfer_size);
    return is_valid_xfer(xfer_size) && aligned && (end_addr <= (ADDR_W+1)'(size));
  endfunction

endpackage

// File: rtl/datamem_lane_sel.sv
// Big-endian byte-lane steering: lane i is the byte at address+i.
module datamem_lane_sel
  import datamem_pkg::*;
(
  input  logic                  wr_valid,
  input  logic                  rd_valid,
  input  logic [SIZE_W-1:0]     xfer_size,
  input  logic [DATA_W-1:0]     write_data,
  input  logic [7:0]            rd_bytes [LANES],
  output logic [LANES-1:0]      wr_en_c,
  output logic [7:0]            wr_bytes_c [LANES],
  output logic [DATA_W-1:0]     read_data_c
);

  logic [2:0] src;

  // Lane i maps to data byte (xfer_size-1-i); lanes beyond the size stay zero
  always_comb begin
    wr_en_c     = '0;
    read_data_c = '0;
    src         = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      wr_bytes_c[i] = '0;
      if (4'(i) < xfer_size) begin
        src           = 3'(xfer_size - 4'(i) - 4'd1);
        wr_en_c[i]    = wr_valid;
        wr_bytes_c[i] = write_data[{src, 3'b000} +: 8];
        if (rd_valid) begin
          read_data_c[{src, 3'b000} +: 8] = rd_bytes[i];
        end
      end
    end
  end

endmodule

// File: rtl/datamem.sv
// Byte-addressed data memory: synchronous big-endian writes, combinational reads.
module datamem
  import datamem_pkg::*;
#(
  parameter int unsigned DATA_MEM_SIZE = DATA_MEM_SIZE_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   address,
  input  logic                write_enable,
  input  logic                read_enable,
  input  logic [DATA_W-1:0]   write_data,
  input  logic [SIZE_W-1:0]   xfer_size,
  output logic [DATA_W-1:0]   read_data
);

  localparam int unsigned AW = $clog2(DATA_MEM_SIZE);

  logic [7:0]       mem_q [DATA_MEM_SIZE];
  logic [7:0]       mem_d [DATA_MEM_SIZE];
  logic             xfer_ok;
  logic [AW-1:0]    base;
  logic [7:0]       rd_bytes [LANES];
  logic [7:0]       wr_bytes [LANES];
  logic [LANES-1:0] wr_en;

  assign xfer_ok = access_ok(address, xfer_size, ADDR_W'(DATA_MEM_SIZE));
  assign base    = address[AW-1:0];

  // Index wraps inside the array; out-of-range lanes are masked by xfer_ok
  always_comb begin
    for (int unsigned i = 0; i < LANES; i++) begin
      rd_bytes[i] = mem_q[AW'(base + AW'(i))];
    end
  end

  datamem_lane_sel u_lane_sel (
    .wr_valid    (write_enable && xfer_ok),
    .rd_valid    (read_enable && xfer_ok),
    .xfer_size   (xfer_size),
    .write_data  (write_data),
    .rd_bytes    (rd_bytes),
    .wr_en_c     (wr_en),
    .wr_bytes_c  (wr_bytes),
    .read_data_c (read_data)
  );

  always_comb begin
    mem_d = mem_q;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (wr_en[i]) begin
        mem_d[AW'(base + AW'(i))] = wr_bytes[i];
      end
    end
  end

  // Reset wins over any write presented on the same edge
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned k = 0; k < DATA_MEM_SIZE; k++) begin
        mem_q[k] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

endmodule

// File: tb/tb_datamem.sv
// Directed plus randomized check of datamem against a byte-array reference model.
module tb_datamem;

  localparam int MEM = 1024;

  logic        clk = 1'b0;
  logic        reset, we, re;
  logic [63:0] addr, wd, rd;
  logic [3:0]  sz;
  logic [7:0]  m [MEM];
  int          checks = 0;
  int          errors = 0;

  datamem dut (
    .clk          (clk),
    .reset        (reset),
    .address      (addr),
    .write_enable (we),
    .read_enable  (re),
    .write_data   (wd),
    .xfer_size    (sz),
    .read_data    (rd)
  );

  always #5 clk = ~clk;

  function automatic bit m_ok(logic [63:0] a, logic [3:0] s);
    if (!(s == 4'd1 || s == 4'd2 || s == 4'd4 || s == 4'd8)) return 1'b0;
    if (a % 64'(s) != 64'd0) return 1'b0;
    return a <= 64'(MEM) - 64'(s);
  endfunction

  function automatic logic [63:0] m_read(logic e, logic [63:0] a, logic [3:0] s);
    logic [63:0] r;
    r = 64'd0;
    if (!e || !m_ok(a, s)) return 64'd0;
    for (int i = 0; i < int'(s); i++) r = (r << 8) | 64'(m[int'(a[9:0]) + i]);
    return r;
  endfunction

  task automatic set(logic r, logic w, logic e, logic [63:0] a, logic [63:0] d, logic [3:0] s);
    reset = r; we = w; re = e; addr = a; wd = d; sz = s;
    #1;
  endtask

  // Clock edge; model commits the same transaction the DUT sees
  task automatic step();
    @(posedge clk);
    if (reset) begin
      for (int k = 0; k < MEM; k++) m[k] = 8'h00;
    end else if (we && m_ok(addr, sz)) begin
      for (int i = 0; i < int'(sz); i++)
        m[int'(addr[9:0]) + i] = 8'(wd >> (8 * (int'(sz) - 1 - i)));
    end
    #1;
  endtask

  task automatic chk(string tag, logic [63:0] exp);
    checks++;
    assert (rd === exp) else begin
      errors++;
      $error("FAIL %s: read_data=%h expected=%h", tag, rd, exp);
    end
  endtask

  task automatic chk_model(string tag);
    chk(tag, m_read(re, addr, sz));
  endtask

  task automatic sweep(string tag);
    for (int a = 0; a < MEM; a += 8) begin
      set(1'b0, 1'b0, 1'b1, 64'(a), 64'd0, 4'd8);
      chk_model(tag);
    end
  endtask

  initial begin
    logic [3:0]  s;
    logic [63:0] a;
    logic [3:0]  sizes [4];
    sizes = '{4'd1, 4'd2, 4'd4, 4'd8};

    set(1'b1, 1'b0, 1'b0, 64'd0, 64'd0, 4'd8);
    step();
    set(1'b0, 1'b0, 1'b1, 64'd0, 64'd0, 4'd8);
    chk("reset_rd0", 64'd0);
    set(1'b0, 1'b0, 1'b1, 64'd1016, 64'd0, 4'd8);
    chk("reset_rd_top", 64'd0);

    set(1'b0, 1'b1, 1'b0, 64'd128, 64'd69, 4'd8);
    step();
    set(1'b0, 1'b0, 1'b1, 64'd128, 64'd0, 4'd8);
    chk("wr128_rd8", 64'd69);

    set(1'b0, 1'b1, 1'b0, 64'd0, 64'h0102030405060708, 4'd8);
    step();
    set(1'b0, 1'b0, 1'b1, 64'd0, 64'd0, 4'd1);  chk("be_rd0_s1", 64'h01);
    set(1'b0, 1'b0, 1'b1, 64'd7, 64'd0, 4'd1);  chk("be_rd7_s1", 64'h08);
    set(1'b0, 1'b0, 1'b1, 64'd4, 64'd0, 4'd4);  chk("be_rd4_s4", 64'h05060708);
    set(1'b0, 1'b0, 1'b1, 64'd2, 64'd0, 4'd2);  chk("be_rd2_s2", 64'h0304);

    set(1'b0, 1'b1, 1'b0, 64'd16, 64'hFFFF_FFFF_FFFF_ABCD, 4'd2);
    step();
    set(1'b0, 1'b0, 1'b1, 64'd16, 64'd0, 4'd8);
    chk("wr16_s2", 64'hABCD_0000_0000_0000);

    // Invalid transfers: read side returns 0, write side changes nothing
    set(1'b0, 1'b1, 1'b1, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 4'd4);
    chk("misalign_rd", 64'd0);
    step();
    set(1'b0, 1'b1, 1'b1, 64'd1024, 64'hFFFF_FFFF_FFFF_FFFF, 4'd8);
    chk("oor_rd", 64'd0);
    step();
    set(1'b0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFFF, 4'd8);
    chk("wrap_rd", 64'd0);
    step();
    set(1'b0, 1'b1, 1'b1, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 4'd3);
    chk("size3_rd", 64'd0);
    step();
    set(1'b0, 1'b0, 1'b1, 64'd0, 64'd0, 4'd8);
    chk("invalid_nochange", 64'h0102030405060708);
    sweep("invalid_sweep");

    set(1'b0, 1'b0, 1'b0, 64'd0, 64'd0, 4'd8);
    chk("re_low", 64'd0);
    set(1'b0, 1'b0, 1'b1, 64'd0, 64'd0, 4'd8);
    chk("re_high", 64'h0102030405060708);

    set(1'b0, 1'b1, 1'b1, 64'd64, 64'hDEAD, 4'd8);
    chk("rw_before", 64'd0);
    step();
    chk("rw_after", 64'hDEAD);
    set(1'b1, 1'b1, 1'b1, 64'd64, 64'h1234, 4'd8);
    step();
    set(1'b0, 1'b0, 1'b1, 64'd64, 64'd0, 4'd8);
    chk("reset_over_wr", 64'd0);
    set(1'b0, 1'b0, 1'b1, 64'd0, 64'd0, 4'd8);
    chk("reset_clears", 64'd0);

    for (int n = 0; n < 400; n++) begin
      s = sizes[$urandom_range(0, 3)];
      if ($urandom_range(0, 9) == 0) s = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 9))
        0:       a = {$urandom(), $urandom()};
        1:       a = 64'($urandom_range(0, MEM - 1));
        default: a = 64'($urandom_range(0, MEM - 1)) & ~(64'(s) - 64'd1);
      endcase
      set($urandom_range(0, 39) == 0, 1'($urandom()), 1'($urandom()), a,
          {$urandom(), $urandom()}, s);
      chk_model("rand_pre");
      step();
      chk_model("rand_post");
    end
    sweep("final_sweep");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
